mul_4b: RTL and testbench



---
 rtl/mul_4b.sv | 70 +++++++
 tb/tb_mul_4b.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_4b.sv
// rtl/mul_4b.sv - sequential 4x4 unsigned shift-and-add multiplier
//
// Free-running loop: one LOAD edge samples the operands, four CALC edges
// accumulate one partial product each, and the last CALC edge publishes
// the product. Iterations repeat back to back every 5 clocks.
//
// Ports:
//   clk  in   1  clock, rising edge
//   a    in   4  multiplicand, unsigned, sampled on LOAD edges only
//   b    in   4  multiplier, unsigned, sampled on LOAD edges only
//   z    out  8  registered product a*b, updated on the final CALC edge
//   rst  in   1  synchronous active-high reset, priority over all updates

module mul_4b (
  input  logic       clk,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] z,
  input  logic       rst
);

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] areg;
  logic [3:0] breg;
  logic [7:0] acc;
  logic [1:0] cnt;
  logic [7:0] sum;

  // Next accumulator value; the true sum never exceeds 225 so 8 bits suffice.
  assign sum = acc + (breg[0] ? areg : 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      areg  <= 8'd0;
      breg  <= 4'd0;
      acc   <= 8'd0;
      cnt   <= 2'd0;
      z     <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          areg  <= {4'b0000, a};
          breg  <= b;
          acc   <= 8'd0;
          cnt   <= 2'd0;
          state <= CALC;
        end
        CALC: begin
          acc  <= sum;
          areg <= areg << 1;
          breg <= breg >> 1;
          cnt  <= cnt + 2'd1;
          // Fourth step: sum already holds the complete product.
          if (cnt == 2'd3) begin
            z     <= sum;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_4b.sv
// tb/tb_mul_4b.sv - directed self-checking bench for mul_4b

module tb_mul_4b;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] z;

  int errors;
  int checks;

  mul_4b dut (
    .clk (clk),
    .a   (a),
    .b   (b),
    .z   (z),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with given operands; returns at the negedge just before LOAD edge 0.
  task automatic do_reset(input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    a   = ra;
    b   = rb;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    a   = 4'd9;
    b   = 4'd9;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (z !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: z=%0d expected 0", i, z);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      checks++;
      if (z !== 8'd0) begin
        errors++;
        $display("FAIL reset_release edge %0d: z=%0d expected 0", e, z);
      end
    end
    @(negedge clk);
    checks++;
    if (z !== 8'd81) begin
      errors++;
      $display("FAIL reset_first_product: z=%0d expected 81", z);
    end
  endtask

  task automatic test_products;
    logic [3:0] ta [5];
    logic [3:0] tb [5];
    logic [7:0] tz [5];
    ta[0] = 4'd2; tb[0] = 4'd2; tz[0] = 8'd4;
    ta[1] = 4'd3; tb[1] = 4'd2; tz[1] = 8'd6;
    ta[2] = 4'd3; tb[2] = 4'd6; tz[2] = 8'h12;
    ta[3] = 4'd5; tb[3] = 4'd2; tz[3] = 8'd10;
    ta[4] = 4'd7; tb[4] = 4'd1; tz[4] = 8'd7;
    for (int i = 0; i < 5; i++) begin
      a = ta[i];
      b = tb[i];
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k >= 9) begin
          checks++;
          if (z !== tz[i]) begin
            errors++;
            $display("FAIL product %0dx%0d cycle %0d: z=%0d expected %0d",
                     ta[i], tb[i], k, z, tz[i]);
          end
        end
      end
    end
  endtask

  task automatic test_boundaries;
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    logic [7:0] tz [4];
    ta[0] = 4'd15; tb[0] = 4'd15; tz[0] = 8'hE1;
    ta[1] = 4'd0;  tb[1] = 4'd13; tz[1] = 8'd0;
    ta[2] = 4'd13; tb[2] = 4'd0;  tz[2] = 8'd0;
    ta[3] = 4'd1;  tb[3] = 4'd15; tz[3] = 8'd15;
    for (int i = 0; i < 4; i++) begin
      a = ta[i];
      b = tb[i];
      repeat (10) @(negedge clk);
      checks++;
      if (z !== tz[i]) begin
        errors++;
        $display("FAIL boundary %0dx%0d: z=%0d expected %0d", ta[i], tb[i], z, tz[i]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        exp = 8'(i * j);
        repeat (10) @(negedge clk);
        checks++;
        if (z !== exp) begin
          errors++;
          $display("FAIL sweep %0dx%0d: z=%0d expected %0d", i, j, z, exp);
        end
      end
    end
  endtask

  task automatic test_mid_change;
    do_reset(4'd3, 4'd5);
    repeat (3) @(negedge clk);       // after edges 0 (LOAD), 1, 2
    a = 4'd12;
    @(negedge clk);                  // after edge 3
    checks++;
    if (z !== 8'd0) begin
      errors++;
      $display("FAIL mid_change_early: z=%0d expected 0", z);
    end
    @(negedge clk);                  // after edge 4
    checks++;
    if (z !== 8'h0F) begin
      errors++;
      $display("FAIL mid_change_first: z=%0d expected 15", z);
    end
    repeat (4) @(negedge clk);       // after edge 8
    checks++;
    if (z !== 8'h0F) begin
      errors++;
      $display("FAIL mid_change_hold: z=%0d expected 15", z);
    end
    @(negedge clk);                  // after edge 9
    checks++;
    if (z !== 8'h3C) begin
      errors++;
      $display("FAIL mid_change_second: z=%0d expected 60", z);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(4'd6, 4'd7);
    repeat (5) @(negedge clk);       // after edge 4
    checks++;
    if (z !== 8'd42) begin
      errors++;
      $display("FAIL mid_reset_pre: z=%0d expected 42", z);
    end
    repeat (2) @(negedge clk);       // after edges 5 (LOAD), 6 (CALC 1)
    rst = 1'b1;                      // sampled on edge 7, the second CALC edge
    @(negedge clk);
    checks++;
    if (z !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: z=%0d expected 0", z);
    end
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      checks++;
      if (z !== 8'd0) begin
        errors++;
        $display("FAIL mid_reset_restart edge %0d: z=%0d expected 0", e, z);
      end
    end
    @(negedge clk);
    checks++;
    if (z !== 8'd42) begin
      errors++;
      $display("FAIL mid_reset_product: z=%0d expected 42", z);
    end
  endtask

  task automatic test_cadence;
    logic [7:0] exp;
    logic [7:0] prev;
    int         last_change;
    // Constant operands: z is 0 through edge 3, then 42 forever.
    do_reset(4'd6, 4'd7);
    for (int e = 0; e < 15; e++) begin
      @(negedge clk);
      exp = (e >= 4) ? 8'd42 : 8'd0;
      checks++;
      if (z !== exp) begin
        errors++;
        $display("FAIL cadence_const edge %0d: z=%0d expected %0d", e, z, exp);
      end
    end
    // Alternate a between 6 and 5 right after each LOAD edge so z toggles
    // 42/35 and every change must land exactly 5 edges after the previous.
    do_reset(4'd6, 4'd7);
    prev        = 8'd0;
    last_change = -1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if ((e % 5) == 0) a = (((e / 5) % 2) == 0) ? 4'd5 : 4'd6;
      if (e < 4) exp = 8'd0;
      else exp = ((((e - 4) / 5) % 2) == 0) ? 8'd42 : 8'd35;
      checks++;
      if (z !== exp) begin
        errors++;
        $display("FAIL cadence_alt edge %0d: z=%0d expected %0d", e, z, exp);
      end
      if (z !== prev) begin
        if (last_change >= 0) begin
          checks++;
          if (e - last_change != 5) begin
            errors++;
            $display("FAIL cadence_spacing edge %0d: spacing=%0d expected 5",
                     e, e - last_change);
          end
        end
        last_change = e;
        prev        = z;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_products();
    test_boundaries();
    test_sweep();
    test_mid_change();
    test_mid_reset();
    test_cadence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
